// File: rtl/enc_pkg.sv
// Shared widths, mask builder and output-field offsets for the additive stream encryptor.
package enc_pkg;

    localparam int unsigned DEF_DATA_W  = 60;
    localparam int unsigned DEF_KEY_W   = 11;
    localparam int unsigned DEF_TAG_W   = 6;

    // Widest DATA_W / KEY_W the mask builder supports.
    localparam int unsigned MASK_MAX_W  = 128;
    localparam int unsigned MASK_IDX_W  = $clog2(MASK_MAX_W);

    // out_data = {sum, key, tag} at the default widths.
    localparam int unsigned OUT_TAG_LSB = 0;
    localparam int unsigned OUT_KEY_LSB = DEF_TAG_W;
    localparam int unsigned OUT_SUM_LSB = DEF_TAG_W + DEF_KEY_W;
    localparam int unsigned OUT_W       = DEF_DATA_W + 1 + DEF_KEY_W + DEF_TAG_W;

    function automatic int unsigned nseg(input int unsigned data_w, input int unsigned key_w);
        return (data_w + key_w - 1) / key_w;
    endfunction

    // Segment i of the mask is key (pattern[i]=0) or ~key (pattern[i]=1); bits at
    // and above data_w stay zero, which truncates the last segment.
    function automatic logic [MASK_MAX_W-1:0] build_mask(
        input logic [MASK_MAX_W-1:0] key,
        input logic [31:0]           pattern,
        input int unsigned           data_w,
        input int unsigned           key_w
    );
        logic [MASK_MAX_W-1:0] m;
        int unsigned           seg;
        int unsigned           off;
        logic                  inv;
        m   = '0;
        seg = 0;
        off = 0;
        for (int unsigned b = 0; b < MASK_MAX_W; b++) begin
            if (b < data_w) begin
                inv = (seg < 32) ? pattern[seg[4:0]] : 1'b0;
                m[b[MASK_IDX_W-1:0]] = key[off[MASK_IDX_W-1:0]] ^ inv;
                off = off + 1;
                if (off == key_w) begin
                    off = 0;
                    seg = seg + 1;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/enc_key_lfsr.sv
// Fibonacci LFSR key source; only present in builds with ENC_INTERNAL_KEYGEN_EN defined.
`ifdef ENC_INTERNAL_KEYGEN_EN
module enc_key_lfsr #(
    parameter int unsigned       KEY_W     = 11,
    parameter logic [KEY_W-1:0]  LFSR_SEED = 11'h5A5,
    parameter logic [KEY_W-1:0]  LFSR_TAPS = 11'h500
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             step,
    output logic [KEY_W-1:0] state
);

    // A zero seed would lock the register at zero forever.
    localparam logic [KEY_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? KEY_W'(1) : LFSR_SEED;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= SEED_EFF;
        end else if (step) begin
            state <= {state[KEY_W-2:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule
`endif

// File: rtl/enc_stream_pipe.sv
// Two-stage valid/ready additive encryptor: out_data = {data + mask, key, tag}.
// ENC_INTERNAL_KEYGEN_EN selects the internal LFSR key; otherwise key_in is sampled on accept.
module enc_stream_pipe
    import enc_pkg::*;
#(
    parameter int unsigned      DATA_W      = DEF_DATA_W,
    parameter int unsigned      KEY_W       = DEF_KEY_W,
    parameter int unsigned      TAG_W       = DEF_TAG_W,
    parameter logic [31:0]      INV_PATTERN = 32'h0000_0016,
    parameter logic [KEY_W-1:0] LFSR_SEED   = 11'h5A5,
    parameter logic [KEY_W-1:0] LFSR_TAPS   = 11'h500
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
`ifndef ENC_INTERNAL_KEYGEN_EN
    input  logic [KEY_W-1:0]              key_in,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W+KEY_W+TAG_W:0]   out_data
);

    localparam int unsigned NSEG    = nseg(DATA_W, KEY_W);
    localparam logic [31:0] SEG_SEL = (NSEG >= 32) ? INV_PATTERN
                                    : (INV_PATTERN & ((32'd1 << NSEG) - 32'd1));

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [KEY_W-1:0]  s1_key;
    logic [TAG_W-1:0]  s1_tag;
    logic [TAG_W-1:0]  tag_cnt;
    logic [KEY_W-1:0]  cur_key;
    logic              s2_ready;
    logic              accept;
    logic [DATA_W-1:0] mask;
    logic [DATA_W:0]   sum;

`ifdef ENC_INTERNAL_KEYGEN_EN
    enc_key_lfsr #(
        .KEY_W     (KEY_W),
        .LFSR_SEED (LFSR_SEED),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_key_lfsr (
        .Clk   (Clk),
        .Rst   (Rst),
        .step  (accept),
        .state (cur_key)
    );
`else
    assign cur_key = key_in;
`endif

    always_comb begin
        s2_ready = !out_valid || out_ready;
        in_ready = !s1_valid || s2_ready;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        mask = DATA_W'(build_mask(MASK_MAX_W'(s1_key), SEG_SEL, DATA_W, KEY_W));
        sum  = {1'b0, s1_data} + {1'b0, mask};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_key    <= '0;
            s1_tag    <= '0;
            tag_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            // Stage 2 loads whenever it is empty or draining this cycle.
            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= {sum, s1_key, s1_tag};
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_data <= in_data;
                s1_key  <= cur_key;
                s1_tag  <= tag_cnt;
                tag_cnt <= tag_cnt + TAG_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_enc_stream_pipe.sv
// Directed self-checking bench for enc_stream_pipe at default parameters.
module tb_enc_stream_pipe;
    import enc_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [59:0] in_data = '0;
    logic [10:0] key_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [77:0] out_data;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [77:0] exp_q[$];
    logic [5:0]  model_tag  = '0;
    logic [10:0] model_lfsr = 11'h5A5;

    enc_stream_pipe dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifndef ENC_INTERNAL_KEYGEN_EN
        .key_in    (key_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 Clk = ~Clk;

    function automatic logic [10:0] lfsr_step(input logic [10:0] s);
        return {s[9:0], s[10] ^ s[8]};
    endfunction

    function automatic logic [77:0] exp_word(input logic [59:0] d, input logic [10:0] k,
                                             input logic [5:0] t);
        logic [127:0] m;
        logic [60:0]  s;
        m = build_mask(128'(k), 32'h16, 60, 11);
        s = {1'b0, d} + {1'b0, m[59:0]};
        return {s, k, t};
    endfunction

    function automatic logic [59:0] stim_data(input int unsigned i);
        return 60'hF0F_0F0F_0F0F_0F0F ^ (60'(i) << 24) ^ 60'(i * 977);
    endfunction

    function automatic logic [10:0] stim_key(input int unsigned i);
        return 11'(i * 173 + 9);
    endfunction

    task automatic model_accept();
        logic [10:0] k;
`ifdef ENC_INTERNAL_KEYGEN_EN
        k = model_lfsr;
        model_lfsr = lfsr_step(model_lfsr);
`else
        k = key_in;
`endif
        exp_q.push_back(exp_word(in_data, k, model_tag));
        model_tag = model_tag + 6'd1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        in_valid = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        exp_q.delete();
        model_tag  = '0;
        model_lfsr = 11'h5A5;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        do_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_data !== 78'h0) $display("FAIL reset_out_data: got %h expected 0", out_data);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else n_pass++;
    endtask

`ifndef ENC_INTERNAL_KEYGEN_EN
    task automatic test_zero_key();
        @(negedge Clk);
        in_valid = 1'b1; in_data = '0; key_in = 11'h000; out_ready = 1'b1;
        #1;
        model_accept();
        @(negedge Clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL zero_key_latency1: out_valid %b expected 0", out_valid);
        else n_pass++;
        @(negedge Clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL zero_key_latency2: out_valid %b expected 1", out_valid);
        else n_pass++;
        n_checks++;
        if (out_data !== {61'h007F_F001_FFFF_F800, 11'h000, 6'h00})
            $display("FAIL zero_key_data: got %h expected %h", out_data,
                     {61'h007F_F001_FFFF_F800, 11'h000, 6'h00});
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_carry();
        @(negedge Clk);
        in_valid = 1'b1; in_data = 60'hFFF_FFFF_FFFF_FFFF; key_in = 11'h7FF;
        #1;
        model_accept();
        @(negedge Clk);
        in_valid = 1'b0;
        @(negedge Clk);
        #1;
        n_checks++;
        if (out_data[77] !== 1'b1) $display("FAIL carry_bit: got %b expected 1", out_data[77]);
        else n_pass++;
        n_checks++;
        if (out_data !== {1'b1, 60'hF80_0FFE_0000_07FE, 11'h7FF, 6'd1})
            $display("FAIL carry_data: got %h expected %h", out_data,
                     {1'b1, 60'hF80_0FFE_0000_07FE, 11'h7FF, 6'd1});
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_key_sampled_on_accept();
        @(negedge Clk);
        in_valid = 1'b1; in_data = 60'h123_4567_89AB_CDEF; key_in = 11'h123; out_ready = 1'b1;
        #1;
        model_accept();
        @(negedge Clk);
        in_valid = 1'b0; key_in = 11'h456;
        @(negedge Clk);
        #1;
        n_checks++;
        if (out_data[OUT_SUM_LSB-1:OUT_KEY_LSB] !== 11'h123)
            $display("FAIL key_sample: got %h expected 123", out_data[OUT_SUM_LSB-1:OUT_KEY_LSB]);
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0 || out_data !== exp_q[0])
            $display("FAIL key_sample_word: got %h expected %h", out_data, exp_q[0]);
        else n_pass++;
        exp_q.delete();
    endtask
`else
    task automatic test_internal_keygen();
        logic [10:0] ref_keys[3];
        int unsigned got = 0;
        int unsigned sent = 0;
        ref_keys[0] = 11'h5A5; ref_keys[1] = 11'h34A; ref_keys[2] = 11'h695;
        do_reset();
        out_ready = 1'b1;
        for (int unsigned c = 0; c < 14; c++) begin
            @(negedge Clk);
            // Gaps between words must not move the key sequence.
            in_valid = (sent < 3) && (c % 4 == 0);
            in_data  = stim_data(200 + sent);
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (got >= 3 || out_data[OUT_SUM_LSB-1:OUT_KEY_LSB] !== ref_keys[got])
                    $display("FAIL lfsr_key%0d: got %h", got, out_data[OUT_SUM_LSB-1:OUT_KEY_LSB]);
                else n_pass++;
                n_checks++;
                if (exp_q.size() == 0 || out_data !== exp_q[0])
                    $display("FAIL lfsr_word%0d: got %h", got, out_data);
                else n_pass++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                model_accept();
                sent++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== 3) $display("FAIL lfsr_count: got %0d expected 3", got);
        else n_pass++;
    endtask
`endif

    task automatic test_back_to_back();
        int unsigned sent = 0;
        int unsigned got = 0;
        int unsigned first_cyc = 0;
        int unsigned last_cyc = 0;
        int unsigned ready_drops = 0;
        logic [5:0]  last_tag = '0;
        do_reset();
        out_ready = 1'b1;
        for (int unsigned c = 0; c < 80; c++) begin
            @(negedge Clk);
            in_valid = (sent < 70);
            in_data  = stim_data(sent);
            key_in   = stim_key(sent);
            #1;
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL b2b_extra: got %h expected none", out_data);
                else if (out_data !== exp_q[0])
                    $display("FAIL b2b_word%0d: got %h expected %h", got, out_data, exp_q[0]);
                else n_pass++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (got == 0) first_cyc = c;
                last_cyc = c;
                last_tag = out_data[OUT_KEY_LSB-1:OUT_TAG_LSB];
                got++;
            end
            if (in_valid && !in_ready) ready_drops++;
            if (in_valid && in_ready) begin
                model_accept();
                sent++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== 70) $display("FAIL b2b_count: got %0d expected 70", got);
        else n_pass++;
        n_checks++;
        if (first_cyc !== 2) $display("FAIL b2b_fill: got %0d expected 2", first_cyc);
        else n_pass++;
        n_checks++;
        if (last_cyc - first_cyc !== 69) $display("FAIL b2b_bubbles: got %0d expected 69", last_cyc - first_cyc);
        else n_pass++;
        n_checks++;
        if (last_tag !== 6'd5) $display("FAIL b2b_last_tag: got %0d expected 5", last_tag);
        else n_pass++;
        n_checks++;
        if (ready_drops !== 0) $display("FAIL b2b_in_ready: got %0d drops expected 0", ready_drops);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int unsigned sent = 0;
        int unsigned got = 0;
        logic [77:0] held = '0;
        logic        held_ok = 1'b1;
        for (int unsigned c = 0; c < 20; c++) begin
            @(negedge Clk);
            out_ready = (c >= 5);
            in_valid  = (sent < 5);
            in_data   = stim_data(100 + sent);
            key_in    = stim_key(100 + sent);
            #1;
            if (c == 2) held = out_data;
            if (c > 2 && c <= 5 && out_data !== held) held_ok = 1'b0;
            if (c == 4) begin
                n_checks++;
                if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready);
                else n_pass++;
                n_checks++;
                if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b expected 1", out_valid);
                else n_pass++;
                n_checks++;
                if (sent !== 2) $display("FAIL bp_accepted: got %0d expected 2", sent);
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL bp_extra: got %h expected none", out_data);
                else if (out_data !== exp_q[0])
                    $display("FAIL bp_word%0d: got %h expected %h", got, out_data, exp_q[0]);
                else n_pass++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                model_accept();
                sent++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (held_ok !== 1'b1) $display("FAIL bp_stable: out_data changed while stalled, held %h", held);
        else n_pass++;
        n_checks++;
        if (got !== 5 || exp_q.size() != 0)
            $display("FAIL bp_drain: got %0d expected 5, %0d left", got, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        int unsigned spurious = 0;
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            @(negedge Clk);
            in_valid = 1'b1;
            in_data  = stim_data(300 + i);
            key_in   = stim_key(300 + i);
        end
        @(negedge Clk);
        in_valid = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        model_tag  = '0;
        model_lfsr = 11'h5A5;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_data !== 78'h0) $display("FAIL midrst_out_data: got %h expected 0", out_data);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready);
        else n_pass++;
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge Clk);
            #1;
            if (out_valid) spurious++;
        end
        n_checks++;
        if (spurious !== 0) $display("FAIL midrst_flush: got %0d outputs expected 0", spurious);
        else n_pass++;
        @(negedge Clk);
        in_valid = 1'b1;
        in_data  = stim_data(400);
        key_in   = 11'h2C3;
        #1;
        model_accept();
        @(negedge Clk);
        in_valid = 1'b0;
        @(negedge Clk);
        #1;
        n_checks++;
        if (out_data[OUT_KEY_LSB-1:OUT_TAG_LSB] !== 6'd0)
            $display("FAIL midrst_tag: got %0d expected 0", out_data[OUT_KEY_LSB-1:OUT_TAG_LSB]);
        else n_pass++;
`ifdef ENC_INTERNAL_KEYGEN_EN
        n_checks++;
        if (out_data[OUT_SUM_LSB-1:OUT_KEY_LSB] !== 11'h5A5)
            $display("FAIL midrst_key: got %h expected 5a5", out_data[OUT_SUM_LSB-1:OUT_KEY_LSB]);
        else n_pass++;
`endif
        n_checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0 || out_data !== exp_q[0])
            $display("FAIL midrst_word: valid %b got %h", out_valid, out_data);
        else n_pass++;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifndef ENC_INTERNAL_KEYGEN_EN
        test_zero_key();
        test_carry();
        test_key_sampled_on_accept();
`else
        test_internal_keygen();
`endif
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
